// File: rtl/cpu7_biu_inst_resp_pkg.sv
// cpu7_biu_inst_resp_pkg: shared state encoding and constants for the instruction fetch BIU
package cpu7_biu_inst_resp_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, EXC} state_e;
  localparam logic [5:0] ADEF = 6'h08;
  localparam logic [3:0] UC_REGION_DEF = 4'hA;
endpackage

// File: rtl/cpu7_biu_inst_resp_if.sv
// cpu7_biu_inst_resp_if: IFU fetch handshake plus memory read channel
interface cpu7_biu_inst_resp_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_cancel;
  logic        inst_ack;
  logic        inst_addr_ok;
  logic        inst_valid_f;
  logic [31:0] inst_rdata_f;
  logic        inst_ex;
  logic [5:0]  inst_exccode;
  logic [1:0]  inst_count;
  logic        inst_uncache;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  modport slave (
    input  inst_req, inst_addr, inst_cancel, mem_gnt, mem_rvalid, mem_rdata,
    output inst_ack, inst_addr_ok, inst_valid_f, inst_rdata_f, inst_ex, inst_exccode,
           inst_count, inst_uncache, mem_req, mem_addr
  );
  modport master (
    output inst_req, inst_addr, inst_cancel, mem_gnt, mem_rvalid, mem_rdata,
    input  inst_ack, inst_addr_ok, inst_valid_f, inst_rdata_f, inst_ex, inst_exccode,
           inst_count, inst_uncache, mem_req, mem_addr
  );
endinterface

// File: rtl/cpu7_biu_inst_resp.sv
// cpu7_biu_inst_resp: single-outstanding instruction fetch bridge with cancel-drain and ADEF handling
module cpu7_biu_inst_resp
  import cpu7_biu_inst_resp_pkg::*;
#(
  parameter logic [3:0] UC_REGION = UC_REGION_DEF
) (
  input  logic clk,
  input  logic reset,
  cpu7_biu_inst_resp_if.slave bus
);
  state_e      state_q, state_d;
  logic        drop_q, drop_d;
  logic [31:0] addr_q, addr_d;
  logic        uc_q, uc_d;
  logic        ack, vld, rsp;
  // state, drop flag and captured fetch attributes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      drop_q  <= 1'b0;
      addr_q  <= '0;
      uc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      addr_q  <= addr_d;
      uc_q    <= uc_d;
    end
  end
  // next-state and response decision; a cancelled fetch still drains its memory response
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    addr_d  = addr_q;
    uc_d    = uc_q;
    rsp     = 1'b0;
    ack     = bus.inst_req && state_q == IDLE && !reset;
    unique case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (ack) begin
          addr_d  = bus.inst_addr;
          uc_d    = bus.inst_addr[31:28] == UC_REGION;
          state_d = |bus.inst_addr[1:0] ? EXC : REQ;
        end
      end
      REQ: begin
        drop_d  = drop_q || bus.inst_cancel;
        state_d = bus.mem_gnt ? WAIT : REQ;
      end
      WAIT: begin
        drop_d  = bus.mem_rvalid ? 1'b0 : (drop_q || bus.inst_cancel);
        state_d = bus.mem_rvalid ? IDLE : WAIT;
        rsp     = bus.mem_rvalid && !drop_q && !bus.inst_cancel;
      end
      EXC: begin
        state_d = IDLE;
        rsp     = !bus.inst_cancel;
      end
    endcase
  end
  assign vld              = rsp && !reset;
  assign bus.inst_ack     = ack;
  assign bus.inst_addr_ok = ack;
  assign bus.inst_valid_f = vld;
  assign bus.inst_rdata_f = (vld && state_q == WAIT) ? bus.mem_rdata : '0;
  assign bus.inst_ex      = vld && state_q == EXC;
  assign bus.inst_exccode = (vld && state_q == EXC) ? ADEF : '0;
  assign bus.inst_count   = {1'b0, vld};
  assign bus.inst_uncache = vld && uc_q;
  assign bus.mem_req      = state_q == REQ;
  assign bus.mem_addr     = state_q == REQ ? addr_q : '0;
endmodule

// File: doc/cpu7_biu_inst_resp.md
CPU7_BIU_INST_RESP -- requirements
Module: cpu7_biu_inst_resp

Interface
REQ-001 Parameter UC_REGION, default 4'hA, is the inst_addr[31:28] value that marks an uncached fetch.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high (ports clk, reset).
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 inst_req  in  1  fetch request from IFU.
REQ-006 inst_addr  in  32  fetch PC, sampled on the accept cycle only.
REQ-007 inst_cancel  in  1  abort the outstanding fetch (branch/exception/ertn redirect).
REQ-008 inst_ack  out  1  request accepted this cycle (combinational).
REQ-009 inst_addr_ok  out  1  identical to inst_ack.
REQ-010 inst_valid_f  out  1  one-cycle pulse: response data/exception valid.
REQ-011 inst_rdata_f  out  32  fetched instruction word, 0 when inst_valid_f=0.
REQ-012 inst_ex  out  1  response carries exception; qualified by inst_valid_f.
REQ-013 inst_exccode  out  6  exception code, 6'h08 (ADEF) or 0.
REQ-014 inst_count  out  2  2'd1 with inst_valid_f, else 2'd0.
REQ-015 inst_uncache  out  1  uncached attribute of the responding fetch, qualified by inst_valid_f.
REQ-016 mem_req  out  1  memory read request, held until mem_gnt.
REQ-017 mem_addr  out  32  word address to memory, stable while mem_req=1.
REQ-018 mem_gnt  in  1  memory accepted mem_req this cycle.
REQ-019 mem_rvalid  in  1  read data returned, exactly one per grant, at least 1 cycle after mem_gnt.
REQ-020 mem_rdata  in  32  read data, valid with mem_rvalid.

Function
REQ-021 FSM states SHALL be IDLE, REQ, WAIT, EXC, plus a 1-bit drop flag; at most one fetch is outstanding.
REQ-022 inst_ack SHALL equal inst_req & (state==IDLE); a request coincident with inst_cancel in IDLE is accepted as a new fetch.
REQ-023 On accept: capture inst_addr and its uncache bit (addr[31:28]==UC_REGION); go to EXC if addr[1:0]!=0, else to REQ.
REQ-024 REQ: mem_req=1, mem_addr=captured address; on mem_gnt go to WAIT.
REQ-025 WAIT: on mem_rvalid return to IDLE and, if drop=0, pulse inst_valid_f with inst_rdata_f=mem_rdata, inst_ex=0 in that same cycle (zero added latency).
REQ-026 EXC: no memory access; next cycle pulse inst_valid_f, inst_ex=1, inst_exccode=6'h08, inst_rdata_f=0, then IDLE.
REQ-027 inst_cancel in REQ or WAIT SHALL set drop; mem_req is NOT withdrawn; the response is consumed silently and drop clears on IDLE entry.
REQ-028 inst_cancel in EXC SHALL suppress the exception pulse and return to IDLE.
REQ-029 inst_cancel coincident with mem_rvalid SHALL suppress inst_valid_f for that response.
REQ-030 mem_rvalid outside WAIT SHALL be ignored; no ack while draining, so inst_req waits.
REQ-031 Best-case fetch latency: accept cycle N, gnt N+1, valid at N+2 earliest.

Reset
REQ-032 reset SHALL force IDLE, drop=0, captured address 0, and all outputs 0 on the next edge, including mid-fetch; the memory side is reset by the same signal.
REQ-033 inst_ack SHALL be 0 while reset=1.

Structure
REQ-034 State encodings, ADEF code 6'h08 and UC_REGION default belong in the shared common header; no sub-modules (single flat FSM).

Verification
REQ-035 Aligned fetch 0x1C000000, gnt +1, rvalid +2 with 0x02800421 -> one inst_valid_f, rdata 0x02800421, count 1, ex 0.
REQ-036 Fetch 0x1C000002 -> no mem_req; next cycle valid, ex 1, exccode 6'h08.
REQ-037 Cancel during WAIT, rvalid 3 cycles later -> no inst_valid_f; new req acked only after rvalid.
REQ-038 Cancel same cycle as mem_rvalid -> valid suppressed; IDLE next cycle.
REQ-039 Fetch 0xA0000000 -> inst_uncache 1 with valid; mem_gnt delayed 5 cycles -> mem_req/mem_addr stable throughout.
REQ-040 reset asserted in WAIT -> next cycle IDLE, all outputs 0, late rvalid ignored.
